// File: rtl/multicycle_control.sv
// Control FSM for the shared multicycle MIPS datapath (one memory port, one ALU).
// Moore-style sequencing of R-type, ori, lw, sw, beq and j with bounded memory waits.
module multicycle_control #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] Op_i,
   input  logic       Mem_ready_i,
   output logic       PCWrite_o,
   output logic       PCWriteCond_o,
   output logic       IorD_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       IRWrite_o,
   output logic       MemtoReg_o,
   output logic       RegDst_o,
   output logic       RegWrite_o,
   output logic       ALUSrcA_o,
   output logic [1:0] ALUSrcB_o,
   output logic [1:0] ALUOp_o,
   output logic [1:0] PCSource_o,
   output logic       Instr_done_o,
   output logic       Mem_timeout_o,
   output logic [3:0] State_o
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ORIEX  = 4'd10,
      ORIWB  = 4'd11
   } state_t;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memtoReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
      logic       instrDone;
      logic       memTimeout;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

   state_t           state;
   state_t           nextState;
   logic [CNT_W-1:0] waitCnt;
   logic [CNT_W-1:0] nextCnt;
   logic             waitState;
   ctrl_t            ctrl;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= FETCH;
         waitCnt <= '0;
      end else begin
         state   <= nextState;
         waitCnt <= nextCnt;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      ctrl      = '0;
      nextState = state;
      nextCnt   = '0;
      waitState = 1'b0;

      case (state)
         FETCH: begin
            waitState     = 1'b1;
            ctrl.memRead  = 1'b1;
            ctrl.aluSrcB  = 2'b01;
            ctrl.irWrite  = Mem_ready_i;
            ctrl.pcWrite  = Mem_ready_i;
            if (Mem_ready_i) nextState = DECODE;
         end
         DECODE: begin
            ctrl.aluSrcB = 2'b11;
            case (Op_i)
               OP_RTYPE:     nextState = EXEC;
               OP_ORI:       nextState = ORIEX;
               OP_LW, OP_SW: nextState = MEMADR;
               OP_BEQ:       nextState = BRANCH;
               OP_J:         nextState = JUMP;
               default: begin
                  // Unknown opcodes retire here as a nop.
                  nextState      = FETCH;
                  ctrl.instrDone = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = 2'b10;
            nextState    = (Op_i == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            waitState    = 1'b1;
            ctrl.memRead = 1'b1;
            ctrl.iorD    = 1'b1;
            if (Mem_ready_i) nextState = MEMWB;
         end
         MEMWB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.memtoReg  = 1'b1;
            ctrl.instrDone = 1'b1;
            nextState      = FETCH;
         end
         MEMWR: begin
            waitState      = 1'b1;
            ctrl.memWrite  = 1'b1;
            ctrl.iorD      = 1'b1;
            ctrl.instrDone = Mem_ready_i;
            if (Mem_ready_i) nextState = FETCH;
         end
         EXEC: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluOp   = 2'b11;
            nextState    = ALUWB;
         end
         ALUWB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.regDst    = 1'b1;
            ctrl.instrDone = 1'b1;
            nextState      = FETCH;
         end
         ORIEX: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = 2'b10;
            ctrl.aluOp   = 2'b10;
            nextState    = ORIWB;
         end
         ORIWB: begin
            ctrl.regWrite  = 1'b1;
            ctrl.instrDone = 1'b1;
            nextState      = FETCH;
         end
         BRANCH: begin
            ctrl.aluSrcA     = 1'b1;
            ctrl.aluOp       = 2'b01;
            ctrl.pcWriteCond = 1'b1;
            ctrl.pcSource    = 2'b01;
            ctrl.instrDone   = 1'b1;
            nextState        = FETCH;
         end
         JUMP: begin
            ctrl.pcWrite   = 1'b1;
            ctrl.pcSource  = 2'b10;
            ctrl.instrDone = 1'b1;
            nextState      = FETCH;
         end
         default: nextState = FETCH;
      endcase

      // Ready in the limit cycle completes the access; the counter only aborts on a miss.
      if (waitState && !Mem_ready_i) begin
         if (waitCnt == LIMIT) begin
            nextState       = FETCH;
            ctrl.memTimeout = 1'b1;
         end else begin
            nextCnt = waitCnt + CNT_W'(1);
         end
      end
   end

   ctrl_t ctrlOut;
   assign ctrlOut = rst_i ? '0 : ctrl;

   assign PCWrite_o     = ctrlOut.pcWrite;
   assign PCWriteCond_o = ctrlOut.pcWriteCond;
   assign IorD_o        = ctrlOut.iorD;
   assign MemRead_o     = ctrlOut.memRead;
   assign MemWrite_o    = ctrlOut.memWrite;
   assign IRWrite_o     = ctrlOut.irWrite;
   assign MemtoReg_o    = ctrlOut.memtoReg;
   assign RegDst_o      = ctrlOut.regDst;
   assign RegWrite_o    = ctrlOut.regWrite;
   assign ALUSrcA_o     = ctrlOut.aluSrcA;
   assign ALUSrcB_o     = ctrlOut.aluSrcB;
   assign ALUOp_o       = ctrlOut.aluOp;
   assign PCSource_o    = ctrlOut.pcSource;
   assign Instr_done_o  = ctrlOut.instrDone;
   assign Mem_timeout_o = ctrlOut.memTimeout;
   assign State_o       = rst_i ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle state/control vectors
// are queued with the stimulus and compared as each cycle is sampled.
module tb_multicycle_control;

   localparam int WAIT_LIMIT = 15;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                          S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
                          S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ORIEX = 4'd10, S_ORIWB = 4'd11;

   localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                          OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                          OP_BAD = 6'b111111;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [5:0] Op_i = '0;
   logic       Mem_ready_i = 1'b0;
   logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
   logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, Instr_done_o, Mem_timeout_o;
   logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
   logic [3:0] State_o;

   multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .Mem_ready_i(Mem_ready_i),
      .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
      .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
      .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
      .PCSource_o(PCSource_o), .Instr_done_o(Instr_done_o), .Mem_timeout_o(Mem_timeout_o),
      .State_o(State_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0] st;
      logic       rdy;
      logic       to;
      logic [5:0] op;
   } item_t;

   item_t sbQ[$];
   int    doneQ[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   string phase = "init";

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s/%s: got %0h expected %0h (cycle %0d)", phase, tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] actVec();
      return {10'd0, PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
              MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o,
              Instr_done_o, Mem_timeout_o, State_o};
   endfunction

   // Expected control vector straight from the per-state behaviour table.
   function automatic logic [31:0] expVec(input item_t it);
      logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, srcA = 0;
      logic [1:0] srcB = 0, aop = 0, psrc = 0;
      logic done = 0;
      case (it.st)
         S_FETCH:  begin mrd = 1; srcB = 2'b01; irw = it.rdy; pcw = it.rdy; end
         S_DECODE: begin
            srcB = 2'b11;
            done = !(it.op inside {OP_R, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J});
         end
         S_MEMADR: begin srcA = 1; srcB = 2'b10; end
         S_MEMRD:  begin mrd = 1; iord = 1; end
         S_MEMWB:  begin rw = 1; m2r = 1; done = 1; end
         S_MEMWR:  begin mwr = 1; iord = 1; done = it.rdy; end
         S_EXEC:   begin srcA = 1; aop = 2'b11; end
         S_ALUWB:  begin rw = 1; rdst = 1; done = 1; end
         S_ORIEX:  begin srcA = 1; srcB = 2'b10; aop = 2'b10; end
         S_ORIWB:  begin rw = 1; done = 1; end
         S_BRANCH: begin srcA = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; done = 1; end
         S_JUMP:   begin pcw = 1; psrc = 2'b10; done = 1; end
         default:  ;
      endcase
      return {10'd0, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srcA, srcB, aop, psrc,
              done, it.to, it.st};
   endfunction

   task automatic pushCycle(input logic [3:0] st, input logic rdy, input logic to, input logic [5:0] op);
      item_t it;
      it.st = st; it.rdy = rdy; it.to = to; it.op = op;
      sbQ.push_back(it);
   endtask

   // Wait-state cycles: 'stall' misses, then either a ready cycle or a timeout miss.
   task automatic pushWait(input logic [3:0] st, input int stall, input bit timeout, input logic [5:0] op);
      for (int i = 0; i < stall; i++) pushCycle(st, 1'b0, 1'b0, op);
      if (timeout) pushCycle(st, 1'b0, 1'b1, op);
      else         pushCycle(st, 1'b1, 1'b0, op);
   endtask

   task automatic pushInstr(input logic [5:0] op, input int stall, input bit timeout);
      logic r;
      r = 1'($urandom_range(0, 1));
      pushCycle(S_FETCH, 1'b1, 1'b0, op);
      pushCycle(S_DECODE, r, 1'b0, op);
      case (op)
         OP_R:   begin pushCycle(S_EXEC, r, 0, op);  pushCycle(S_ALUWB, ~r, 0, op); end
         OP_ORI: begin pushCycle(S_ORIEX, r, 0, op); pushCycle(S_ORIWB, ~r, 0, op); end
         OP_LW: begin
            pushCycle(S_MEMADR, ~r, 0, op);
            pushWait(S_MEMRD, stall, timeout, op);
            if (!timeout) pushCycle(S_MEMWB, r, 0, op);
         end
         OP_SW: begin
            pushCycle(S_MEMADR, ~r, 0, op);
            pushWait(S_MEMWR, stall, timeout, op);
         end
         OP_BEQ: pushCycle(S_BRANCH, r, 0, op);
         OP_J:   pushCycle(S_JUMP, r, 0, op);
         default: ;
      endcase
   endtask

   // Drive each queued cycle after the rising edge, compare at the falling edge.
   task automatic runQueue();
      item_t it;
      while (sbQ.size() > 0) begin
         it = sbQ.pop_front();
         Op_i = it.op;
         Mem_ready_i = it.rdy;
         @(negedge clk_i);
         cyc++;
         check($sformatf("state%0d", it.st), actVec(), expVec(it));
         if (Instr_done_o && doneQ.size() > 0) check("doneCycle", cyc, doneQ.pop_front());
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic holdReset(input int cycles);
      rst_i = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         Mem_ready_i = 1'($urandom_range(0, 1));
         Op_i = 6'($urandom_range(0, 63));
         @(negedge clk_i);
         check("resetOutputs", actVec(), 32'd0);
         @(posedge clk_i);
         #1;
      end
      rst_i = 1'b0;
   endtask

   initial begin
      phase = "reset";
      holdReset(2);

      phase = "zeroWait";
      cyc = 0;
      pushInstr(OP_R, 0, 0);   pushInstr(OP_ORI, 0, 0); pushInstr(OP_LW, 0, 0);
      pushInstr(OP_SW, 0, 0);  pushInstr(OP_BEQ, 0, 0); pushInstr(OP_J, 0, 0);
      doneQ = '{4, 8, 13, 17, 20, 23};
      runQueue();
      check("doneLeft", doneQ.size(), 0);

      phase = "lwStall";
      cyc = 0;
      pushInstr(OP_LW, 3, 0);
      doneQ = '{8};
      runQueue();
      check("doneLeft", doneQ.size(), 0);

      phase = "fetchTimeout";
      pushWait(S_FETCH, WAIT_LIMIT, 1, OP_J);
      // Counter must have cleared: another full run of misses and a ready at the limit.
      for (int i = 0; i < WAIT_LIMIT; i++) pushCycle(S_FETCH, 1'b0, 1'b0, OP_J);
      pushInstr(OP_J, 0, 0);
      runQueue();

      phase = "swReadyAtLimit";
      pushInstr(OP_SW, WAIT_LIMIT, 0);
      runQueue();

      phase = "lwTimeout";
      pushInstr(OP_LW, WAIT_LIMIT, 1);
      pushInstr(OP_ORI, 0, 0);
      runQueue();

      phase = "badOpcode";
      pushInstr(OP_BAD, 0, 0);
      pushInstr(OP_BEQ, 0, 0);
      runQueue();

      phase = "midReset";
      pushCycle(S_FETCH, 1'b1, 1'b0, OP_LW);
      pushCycle(S_DECODE, 1'b1, 1'b0, OP_LW);
      pushCycle(S_MEMADR, 1'b0, 1'b0, OP_LW);
      pushWait(S_MEMRD, 2, 0, OP_LW);
      void'(sbQ.pop_back());
      pushCycle(S_MEMRD, 1'b0, 1'b0, OP_LW);
      runQueue();
      holdReset(3);
      pushCycle(S_FETCH, 1'b0, 1'b0, OP_R);
      pushInstr(OP_R, 0, 0);
      runQueue();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: one memory port, one ALU, register file, PC and IR.
- Supported opcodes: R-type, ori, lw, sw, beq and j. Each instruction takes 3–5 states.
- Decodes Op_i (IR[31:26]), drives every datapath select/enable, and waits on a memory ready handshake with a bounded-wait timeout.
- Sits between the IR and the datapath. Replaces single-cycle decode in the multicycle core.

Parameters:
- WAIT_LIMIT, 15: max consecutive not-ready cycles tolerated in a memory state before abort (1..255).
- CNT_W, 8: width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- Op_i  in  6  opcode field of IR
- Mem_ready_i  in  1  memory completes the current access this cycle
- PCWrite_o  out  1  unconditional PC load
- PCWriteCond_o  out  1  PC load if ALU zero (beq)
- IorD_o  out  1  0 = PC address, 1 = ALUOut address
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  IR load
- MemtoReg_o  out  1  register write data from MDR
- RegDst_o  out  1  1 = rd, 0 = rt
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  0 = PC, 1 = A
- ALUSrcB_o  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- ALUOp_o  out  2  00 = add, 01 = sub, 10 = or, 11 = funct
- PCSource_o  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- Instr_done_o  out  1  one-cycle pulse in an instruction's final cycle
- Mem_timeout_o  out  1  one-cycle pulse on wait abort
- State_o  out  4  current state code (debug)

Behaviour:
- Reset:
  - rst_i high forces state FETCH (0) and clears the wait counter.
  - All outputs are gated to 0 while rst_i is high, including the FETCH controls; State_o reads 0.
  - Reset asserted mid-instruction abandons that instruction.
  - First FETCH controls appear in the cycle after rst_i deasserts.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ORIEX 10, ORIWB 11.
  - Codes 12–15 are illegal and go to FETCH on the next cycle.
- Outputs are combinational from state, plus Mem_ready_i where noted. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=Mem_ready_i.
  - Ready → DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op_i:
  - 000000 → EXEC
  - 001101 → ORIEX
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - any other opcode → FETCH with Instr_done_o=1 (treated as nop)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEMRD (lw) or MEMWR (sw). Op_i is held stable by the IR.
- MEMRD: MemRead=1, IorD=1. Ready → MEMWB; otherwise stay.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, Instr_done=1 → FETCH.
- MEMWR: MemWrite=1, IorD=1. Instr_done=Mem_ready_i. Ready → FETCH; otherwise stay.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=11 → ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, Instr_done=1 → FETCH.
- ORIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=10 → ORIWB.
- ORIWB: RegWrite=1, RegDst=0, MemtoReg=0, Instr_done=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, Instr_done=1 → FETCH.
- JUMP: PCWrite=1, PCSource=10, Instr_done=1 → FETCH.
- Latency with zero-wait memory: R/ori 4 cycles, lw 5, sw 4, beq 3, j 3.
- Wait counter:
  - Applies in the wait states FETCH, MEMRD and MEMWR.
  - Increments each cycle Mem_ready_i=0, saturating at WAIT_LIMIT.
  - Clears on any state change and on a ready cycle.
- Timeout:
  - Triggers when counter == WAIT_LIMIT and Mem_ready_i=0 in the same cycle.
  - Next state is FETCH; Mem_timeout_o pulses that cycle; counter clears; no write strobes are taken.
  - From FETCH this restarts the fetch.
  - Ready in the limit cycle wins: the access completes and no timeout occurs.

Test Plan:
- Reset: hold rst_i 3 cycles mid-MEMRD → all outputs 0, State_o=0; after release, MemRead_o=1, IorD_o=0, State_o=0.
- Zero-wait sequence R, ori, lw, sw, beq, j (Mem_ready_i=1) → Instr_done_o pulses at cycles 4, 8, 13, 17, 20, 23.
  - Check every per-state output vector against the Behaviour table.
- lw with 3-cycle memory stall in MEMRD → RegWrite_o=0 during the stall; MEMWB reached on the ready cycle +1; total 8 cycles.
- WAIT_LIMIT=15, Mem_ready_i=0 in FETCH → after 15 wait cycles, the 16th not-ready cycle gives Mem_timeout_o=1 and State_o=0; IRWrite_o is never 1.
- Ready in the exact limit cycle in MEMWR → MemWrite completes, Instr_done_o=1, Mem_timeout_o=0.
- Undefined opcode 111111 in DECODE → next state FETCH, Instr_done_o=1, no RegWrite/MemWrite/PCWrite asserted.
